// File: rtl/rover_mission_controller_if.sv
// Mission-controller bus: locator, path-calculator and IR-transmitter handshakes
// plus mission status. The controller connects through the slave modport.
interface rover_mission_controller_if;
  logic        go;
  logic        abort;
  logic [3:0]  target_location;
  logic [11:0] rover_location;
  logic        loc_valid;
  logic        loc_request;
  logic        calc_enable;
  logic        calc_orientation_done;
  logic [11:0] move_command;
  logic [11:0] tx_command;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        arrived;
  logic        failed;
  logic [3:0]  pass_count;
  logic [3:0]  state;

  modport slave (
    input  go, abort, target_location, rover_location, loc_valid,
           calc_orientation_done, move_command, tx_busy,
    output loc_request, calc_enable, tx_command, tx_start, busy, arrived,
           failed, pass_count, state
  );

  modport master (
    output go, abort, target_location, rover_location, loc_valid,
           calc_orientation_done, move_command, tx_busy,
    input  loc_request, calc_enable, tx_command, tx_start, busy, arrived,
           failed, pass_count, state
  );
endinterface

// File: rtl/rover_mission_controller.sv
// Move-measure-correct mission sequencer for the rover.
// Optional TX_WAIT/SCAN watchdog enabled by defining MISSION_TIMEOUT_EN.
module rover_mission_controller #(
  parameter logic [23:0] SETTLE_CYCLES  = 24'd2_700_000,
  parameter logic [3:0]  MAX_PASSES     = 4'd8,
  parameter logic [7:0]  CLOSE_R        = 8'd10,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd13_500_000
) (
  input  logic                        clock,
  input  logic                        reset,
  rover_mission_controller_if.slave   bus
);

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned LOC_W  = 12;
  localparam int unsigned PASS_W = 4;

  // A settle length of zero behaves as a single cycle.
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    (SETTLE_CYCLES == 24'd0) ? 24'd0 : SETTLE_CYCLES - 24'd1;
  localparam logic [CNT_W-1:0] CMD_WAIT_LAST = 24'd1;
  localparam logic [PASS_W-1:0] PASS_SAT = 4'hF;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ARM      = 4'd1,
    CMD_WAIT = 4'd2,
    TX_START = 4'd3,
    TX_WAIT  = 4'd4,
    SETTLE   = 4'd5,
    SCAN     = 4'd6,
    CALC     = 4'd7,
    CHECK    = 4'd8
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          target_q, target_d;
  logic [LOC_W-1:0]    loc_q, loc_d;
  logic                seen_busy_q, seen_busy_d;
  logic [PASS_W-1:0]   pass_count_q, pass_count_d;
  logic                arrived_q, arrived_d;
  logic                failed_q, failed_d;
  logic                busy_q, busy_d;
  logic [LOC_W-1:0]    tx_command_q, tx_command_d;
  logic                calc_enable_q, calc_enable_d;
  logic                loc_request_q, loc_request_d;
  logic                tx_start_q, tx_start_d;
  logic [PASS_W-1:0]   pass_next;
  logic                at_target;

`ifdef MISSION_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES == 24'd0) ? 24'd0 : TIMEOUT_CYCLES - 24'd1;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             wd_expired;
`else
  logic [CNT_W-1:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
`endif

  // Pass counter saturates so it can never wrap past the budget compare.
  assign pass_next = (pass_count_q == PASS_SAT) ? pass_count_q
                                                : pass_count_q + PASS_W'(1);
  assign at_target = (loc_q[11:8] == target_q) && (loc_q[7:0] <= CLOSE_R);

`ifdef MISSION_TIMEOUT_EN
  assign wd_expired = (wd_q >= WD_LAST);
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    target_d      = target_q;
    loc_d         = loc_q;
    seen_busy_d   = seen_busy_q;
    pass_count_d  = pass_count_q;
    arrived_d     = arrived_q;
    failed_d      = failed_q;
    tx_command_d  = tx_command_q;
    calc_enable_d = 1'b0;
    tx_start_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.go) begin
          arrived_d    = 1'b0;
          failed_d     = 1'b0;
          pass_count_d = '0;
          target_d     = bus.target_location;
          state_d      = ARM;
        end
      end
      ARM: begin
        calc_enable_d = 1'b1;
        cnt_d         = '0;
        state_d       = CMD_WAIT;
      end
      CMD_WAIT: begin
        if (cnt_q == CMD_WAIT_LAST) begin
          tx_command_d = bus.move_command;
          state_d      = TX_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_START: begin
        tx_start_d  = 1'b1;
        seen_busy_d = 1'b0;
        state_d     = TX_WAIT;
      end
      TX_WAIT: begin
        if (bus.tx_busy) begin
          seen_busy_d = 1'b1;
        end
        if (!bus.tx_busy && seen_busy_q) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end
`ifdef MISSION_TIMEOUT_EN
        else if (wd_expired) begin
          failed_d = 1'b1;
          state_d  = IDLE;
        end
`endif
      end
      SETTLE: begin
        if (cnt_q >= SETTLE_LAST) begin
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SCAN: begin
        if (bus.loc_valid) begin
          loc_d         = bus.rover_location;
          calc_enable_d = 1'b1;
          state_d       = CALC;
        end
`ifdef MISSION_TIMEOUT_EN
        else if (wd_expired) begin
          failed_d = 1'b1;
          state_d  = IDLE;
        end
`endif
      end
      CALC: begin
        if (bus.calc_orientation_done) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (at_target) begin
          arrived_d = 1'b1;
          state_d   = IDLE;
        end else begin
          pass_count_d = pass_next;
          if (pass_next == MAX_PASSES) begin
            failed_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = ARM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    loc_request_d = (state_d == SCAN) && (state_q != SCAN);

    // Abort wins over everything and leaves mission status untouched.
    if (bus.abort) begin
      state_d       = IDLE;
      arrived_d     = arrived_q;
      failed_d      = failed_q;
      pass_count_d  = pass_count_q;
      target_d      = target_q;
      tx_command_d  = tx_command_q;
      calc_enable_d = 1'b0;
      loc_request_d = 1'b0;
      tx_start_d    = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

`ifdef MISSION_TIMEOUT_EN
  // Shared watchdog restarts on every state change and counts only while waiting.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) begin
      wd_d = '0;
    end else if ((state_q == TX_WAIT) || (state_q == SCAN)) begin
      wd_d = wd_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      target_q      <= '0;
      loc_q         <= '0;
      seen_busy_q   <= 1'b0;
      pass_count_q  <= '0;
      arrived_q     <= 1'b0;
      failed_q      <= 1'b0;
      busy_q        <= 1'b0;
      tx_command_q  <= '0;
      calc_enable_q <= 1'b0;
      loc_request_q <= 1'b0;
      tx_start_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      loc_q         <= loc_d;
      seen_busy_q   <= seen_busy_d;
      pass_count_q  <= pass_count_d;
      arrived_q     <= arrived_d;
      failed_q      <= failed_d;
      busy_q        <= busy_d;
      tx_command_q  <= tx_command_d;
      calc_enable_q <= calc_enable_d;
      loc_request_q <= loc_request_d;
      tx_start_q    <= tx_start_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.busy        = busy_q;
  assign bus.arrived     = arrived_q;
  assign bus.failed      = failed_q;
  assign bus.pass_count  = pass_count_q;
  assign bus.tx_command  = tx_command_q;
  assign bus.calc_enable = calc_enable_q;
  assign bus.loc_request = loc_request_q;
  assign bus.tx_start    = tx_start_q;

endmodule

// File: tb/tb_rover_mission_controller.sv
// Directed bench for rover_mission_controller: table of whole missions plus
// hand-written abort, stray loc_valid, stuck transmitter and mid-mission reset cases.
module tb_rover_mission_controller;

  localparam logic [23:0] SETTLE = 24'd4;
  localparam logic [3:0]  MAXP   = 4'd2;
  localparam logic [7:0]  CLOSE  = 8'd10;
  localparam logic [23:0] TMO    = 24'd20;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rover_mission_controller_if bus();

  rover_mission_controller #(
    .SETTLE_CYCLES (SETTLE),
    .MAX_PASSES    (MAXP),
    .CLOSE_R       (CLOSE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int n_tx  = 0;
  int n_req = 0;
  int n_dbl = 0;
  bit prev_tx = 1'b0, prev_req = 1'b0, prev_cen = 1'b0;

  // Strobe monitor, sampled shortly after each rising edge.
  always @(posedge clock) begin
    #2;
    if (bus.tx_start === 1'b1) n_tx++;
    if (bus.loc_request === 1'b1) n_req++;
    if ((bus.tx_start === 1'b1 && prev_tx) || (bus.loc_request === 1'b1 && prev_req) ||
        (bus.calc_enable === 1'b1 && prev_cen))
      n_dbl++;
    prev_tx  = (bus.tx_start === 1'b1);
    prev_req = (bus.loc_request === 1'b1);
    prev_cen = (bus.calc_enable === 1'b1);
  end

  typedef struct {
    logic [3:0]  tgt;
    logic [11:0] loc;
    logic [11:0] mv;
    logic        exp_arr;
    logic        exp_fail;
    logic [3:0]  exp_pass;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // which: 0 tx_start, 1 loc_request, 2 busy low. Returns negedges waited.
  task automatic wait_out(input int which, input int limit, output int cyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < limit) begin
      @(negedge clock);
      cyc++;
      case (which)
        0:       hit = (bus.tx_start === 1'b1);
        1:       hit = (bus.loc_request === 1'b1);
        default: hit = (bus.busy === 1'b0);
      endcase
    end
    chk($sformatf("wait_event_%0d", which), 32'(hit), 32'd1);
  endtask

  task automatic start_mission(input logic [3:0] tgt, input logic [11:0] mv);
    @(negedge clock);
    bus.target_location = tgt;
    bus.move_command    = mv;
    bus.go              = 1'b1;
    @(negedge clock);
    bus.go = 1'b0;
    chk("arm_state", 32'(bus.state), 32'd1);
    chk("busy_after_go", 32'(bus.busy), 32'd1);
    chk("flags_clear", 32'({bus.arrived, bus.failed, bus.pass_count}), 32'd0);
    chk("cen_early", 32'(bus.calc_enable), 32'd0);
    @(negedge clock);
    chk("go_to_cen", 32'(bus.calc_enable), 32'd1);
  endtask

  task automatic serve_tx();
    int c;
    wait_out(0, 40, c);
    bus.tx_busy = 1'b1;
    repeat (3) @(negedge clock);
    bus.tx_busy = 1'b0;
  endtask

  task automatic give_loc(input logic [11:0] loc);
    bus.rover_location = loc;
    bus.loc_valid      = 1'b1;
    @(negedge clock);
    bus.loc_valid = 1'b0;
    chk("loc_to_cen", 32'(bus.calc_enable), 32'd1);
    bus.calc_orientation_done = 1'b1;
    @(negedge clock);
    bus.calc_orientation_done = 1'b0;
  endtask

  task automatic serve_scan(input logic [11:0] loc, input bit chk_lat);
    int c;
    wait_out(1, 40, c);
    if (chk_lat) chk("settle_latency", 32'(c), 32'(SETTLE) + 32'd1);
    give_loc(loc);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int tx0, rq0, c, passes;
    passes = v.exp_arr ? 1 : int'(MAXP);
    tx0 = n_tx;
    rq0 = n_req;
    start_mission(v.tgt, v.mv);
    for (int p = 0; p < passes; p++) begin
      serve_tx();
      serve_scan(v.loc, 1'b1);
    end
    wait_out(2, 20, c);
    chk($sformatf("v%0d_arrived", idx), 32'(bus.arrived), 32'(v.exp_arr));
    chk($sformatf("v%0d_failed", idx), 32'(bus.failed), 32'(v.exp_fail));
    chk($sformatf("v%0d_pass", idx), 32'(bus.pass_count), 32'(v.exp_pass));
    chk($sformatf("v%0d_state", idx), 32'(bus.state), 32'd0);
    chk($sformatf("v%0d_txcmd", idx), 32'(bus.tx_command), 32'(v.mv));
    chk($sformatf("v%0d_ntx", idx), 32'(n_tx - tx0), 32'(passes));
    chk($sformatf("v%0d_nreq", idx), 32'(n_req - rq0), 32'(passes));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
    chk({tag, "_status"}, 32'({bus.busy, bus.arrived, bus.failed, bus.pass_count}), 32'd0);
    chk({tag, "_txcmd"}, 32'(bus.tx_command), 32'd0);
    chk({tag, "_strobes"}, 32'({bus.tx_start, bus.loc_request, bus.calc_enable}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c, rq0;
    vecs[0] = '{4'd3,  12'h30A, 12'h0A5, 1'b1, 1'b0, 4'd0};
    vecs[1] = '{4'd5,  12'h340, 12'h123, 1'b0, 1'b1, 4'd2};
    vecs[2] = '{4'd3,  12'h30B, 12'hFFF, 1'b0, 1'b1, 4'd2};
    vecs[3] = '{4'd3,  12'h300, 12'h800, 1'b1, 1'b0, 4'd0};
    vecs[4] = '{4'd4,  12'h30A, 12'h07F, 1'b0, 1'b1, 4'd2};
    vecs[5] = '{4'd15, 12'hF00, 12'h555, 1'b1, 1'b0, 4'd0};
    vecs[6] = '{4'd0,  12'h00A, 12'hAAA, 1'b1, 1'b0, 4'd0};

    bus.go = 1'b0;
    bus.abort = 1'b0;
    bus.target_location = '0;
    bus.rover_location = '0;
    bus.loc_valid = 1'b0;
    bus.calc_orientation_done = 1'b0;
    bus.move_command = '0;
    bus.tx_busy = 1'b0;

    #2 reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk_reset_outputs("por");
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort during the second pass's settle window.
    start_mission(4'd5, 12'h321);
    serve_tx();
    serve_scan(12'h340, 1'b0);
    serve_tx();
    @(negedge clock);
    chk("abort_in_settle", 32'(bus.state), 32'd5);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    chk("abort_state", 32'(bus.state), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_pass", 32'(bus.pass_count), 32'd1);
    chk("abort_flags", 32'({bus.arrived, bus.failed}), 32'd0);
    rq0 = n_req;
    repeat (10) @(negedge clock);
    chk("abort_no_req", 32'(n_req - rq0), 32'd0);

    // Stray loc_valid in SETTLE must be ignored; the SCAN sample decides.
    start_mission(4'd3, 12'h246);
    serve_tx();
    @(negedge clock);
    chk("stray_in_settle", 32'(bus.state), 32'd5);
    bus.rover_location = 12'h1FF;
    bus.loc_valid = 1'b1;
    @(negedge clock);
    bus.loc_valid = 1'b0;
    serve_scan(12'h30A, 1'b0);
    wait_out(2, 20, c);
    chk("stray_arrived", 32'({bus.arrived, bus.failed}), 32'd2);
    chk("stray_pass", 32'(bus.pass_count), 32'd0);

    // Transmitter never goes busy.
    start_mission(4'd3, 12'h135);
    wait_out(0, 40, c);
`ifdef MISSION_TIMEOUT_EN
    repeat (19) @(negedge clock);
    chk("wd_not_yet", 32'(bus.failed), 32'd0);
    @(negedge clock);
    chk("wd_failed", 32'(bus.failed), 32'd1);
    chk("wd_idle", 32'(bus.state), 32'd0);
    chk("wd_busy", 32'(bus.busy), 32'd0);
`else
    repeat (40) @(negedge clock);
    chk("stuck_tx_wait", 32'(bus.state), 32'd4);
    chk("stuck_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    chk("stuck_abort", 32'(bus.state), 32'd0);
    chk("stuck_failed", 32'(bus.failed), 32'd0);
`endif

    // Asynchronous reset while waiting in CALC.
    start_mission(4'd3, 12'h777);
    serve_tx();
    wait_out(1, 40, c);
    bus.rover_location = 12'h340;
    bus.loc_valid = 1'b1;
    @(negedge clock);
    bus.loc_valid = 1'b0;
    chk("in_calc", 32'(bus.state), 32'd7);
    #1 reset = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_vec(7, vecs[0]);

    chk("strobe_double", 32'(n_dbl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
